music_player_ctrl: RTL and testbench
====================================

Name: music_player_ctrl

Overview:
- Parametrised successor of the player's control path: song sequencer, NewFrame synchroniser and beat-base generator in one block.
- Drives the song reader and note player through play, reset_play, song, ready and beat.
- Adds over the previous generation:
  - configurable song count
  - previous-song control
  - four end-of-song modes
  - optional beat realignment on song switch

Parameters:
- NUM_SONGS, 4: number of songs, minimum 2, need not be a power of two.
- SONG_BITS, 2: width of song; must equal ceil(log2(NUM_SONGS)).
- BEAT_DIV, 1000: ready pulses per beat when sim=0.
- BEAT_BITS, 10: beat counter width; 2^BEAT_BITS must be >= BEAT_DIV.
- sim, 0: when 1, the beat divisor is 64 instead of BEAT_DIV.
- BEAT_SYNC, 1: when 1, reset_play clears the beat counter.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-high reset.
- play_pause  in  1  play/pause toggle, high synchronous one-cycle pulse.
- next  in  1  next-song request, high synchronous one-cycle pulse.
- prev  in  1  previous-song request, high synchronous one-cycle pulse.
- mode  in  2  end-of-song mode: 00 single, 01 sequential, 10 loop-all, 11 repeat-one.
- song_done  in  1  end of song from the song reader, one-cycle pulse.
- NewFrame  in  1  asynchronous high pulse requesting a new sample.
- play  out  1  high while in the PLAY state.
- reset_play  out  1  high while in the INIT or SWITCH state.
- song  out  SONG_BITS  current song index.
- ready  out  1  synchronised one-cycle sampling pulse.
- beat  out  1  one-cycle beat-base pulse.

Behaviour:
- Reset (asynchronous, immediate, including mid-song):
  - state=INIT, song=0, play=0, reset_play=1.
  - Synchroniser flops and beat counter are cleared.
- Outputs are Moore and registered.
  - play = (state==PLAY).
  - reset_play = (state==INIT or state==SWITCH).
  - song changes on the same edge that enters SWITCH.
- State machine: INIT, PAUSE, PLAY, SWITCH, plus a 1-bit resume register.
- INIT: lasts one cycle after reset deasserts, then goes to PAUSE.
- PAUSE, in priority order:
  - next: song=inc(song), resume=0, go to SWITCH.
  - else prev: song=dec(song), resume=0, go to SWITCH.
  - else play_pause: go to PLAY.
  - song_done is ignored.
- PLAY, in priority order:
  - next: song=inc(song), resume=1, go to SWITCH.
  - else prev: song=dec(song), resume=1, go to SWITCH.
  - else song_done, per mode:
    - 00 single: song=inc, resume=0.
    - 01 sequential: if song==NUM_SONGS-1 then song=0, resume=0; otherwise song=inc, resume=1.
    - 10 loop-all: song=inc, resume=1.
    - 11 repeat-one: song unchanged, resume=1.
    - In every mode, go to SWITCH.
  - else play_pause: go to PAUSE.
- SWITCH: exactly one cycle with reset_play=1 and play=0, then go to PLAY if resume=1, else PAUSE.
- All control inputs are ignored in INIT and SWITCH.
- inc/dec wrap at NUM_SONGS:
  - inc(NUM_SONGS-1)=0.
  - dec(0)=NUM_SONGS-1.
  - song never holds a value >= NUM_SONGS.
- Synchroniser: two flops, then a rising-edge detector.
  - If NewFrame is first sampled high at edge k, ready is high for exactly the cycle after edge k+2.
  - A NewFrame held high for many cycles produces one ready pulse.
  - A new ready pulse requires NewFrame to go low for at least one sampled cycle first.
- Beat counter: D = sim ? 64 : BEAT_DIV.
  - Increments on ready and wraps from D-1 to 0.
  - beat = ready AND (count==D-1), combinational from the registered count and registered ready.
  - If BEAT_SYNC=1, reset_play synchronously clears the count.
  - If ready coincides with reset_play, the clear wins and beat stays low.

Test Plan:
- Reset with NUM_SONGS=3, then release -> reset_play=1 for exactly 1 cycle; then PAUSE with song=0, play=0.
- Pulse play_pause; then prev; then next twice:
  - play=1 the cycle after play_pause.
  - prev gives song=2 with one reset_play cycle, then play=1.
  - The two next pulses give 0, then 1.
- mode=01, song=2, PLAY, song_done -> song=0, one reset_play cycle, PAUSE with play=0. mode=11, song=1, song_done -> song stays 1, play resumes after 1 cycle.
- next and song_done in the same cycle with mode=11, song=0 -> song=1 (next wins), a single SWITCH cycle.
- sim=1, NewFrame pulses spaced 5 clocks, each held 3 clocks:
  - One ready per pulse, 2 clocks after first sampled high.
  - beat on every 64th ready.
  - A switch after 30 readies restarts the count, so the next beat comes 64 readies after the switch.
- Assert reset during PLAY with song=2 -> play=0, reset_play=1 and song=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/music_player_ctrl.sv
// Music player control path: song sequencer, NewFrame synchroniser
// and beat-base generator.
module music_player_ctrl #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_BITS = 2,
  parameter int BEAT_DIV  = 1000,
  parameter int BEAT_BITS = 10,
  parameter int sim       = 0,
  parameter int BEAT_SYNC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_pause,
  input  logic                 next,
  input  logic                 prev,
  input  logic [1:0]           mode,
  input  logic                 song_done,
  input  logic                 NewFrame,
  output logic                 play,
  output logic                 reset_play,
  output logic [SONG_BITS-1:0] song,
  output logic                 ready,
  output logic                 beat
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_PAUSE  = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;
  localparam logic [1:0] S_SWITCH = 2'd3;

  localparam logic [SONG_BITS-1:0] LAST = SONG_BITS'(NUM_SONGS - 1);

  localparam int                   D   = (sim != 0) ? 64 : BEAT_DIV;
  localparam logic [BEAT_BITS-1:0] DM1 = BEAT_BITS'(D - 1);

  logic [1:0]           state_q, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic                 resume_q, resume_d;
  logic [SONG_BITS-1:0] song_inc, song_dec;

  logic                 s1_q, s2_q, s3_q, ready_q;
  logic [BEAT_BITS-1:0] cnt_q, cnt_d;
  logic                 clr;

  assign song_inc = (song_q == LAST) ? '0 : song_q + SONG_BITS'(1);
  assign song_dec = (song_q == '0) ? LAST : song_q - SONG_BITS'(1);

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    unique case (state_q)
      S_INIT: state_d = S_PAUSE;
      S_PAUSE: begin
        if (next) begin
          song_d   = song_inc;
          resume_d = 1'b0;
          state_d  = S_SWITCH;
        end else if (prev) begin
          song_d   = song_dec;
          resume_d = 1'b0;
          state_d  = S_SWITCH;
        end else if (play_pause) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (next) begin
          song_d   = song_inc;
          resume_d = 1'b1;
          state_d  = S_SWITCH;
        end else if (prev) begin
          song_d   = song_dec;
          resume_d = 1'b1;
          state_d  = S_SWITCH;
        end else if (song_done) begin
          state_d = S_SWITCH;
          unique case (mode)
            2'b00: begin
              song_d   = song_inc;
              resume_d = 1'b0;
            end
            // sequential stops after wrapping past the last song
            2'b01: begin
              song_d   = song_inc;
              resume_d = (song_q != LAST);
            end
            2'b10: begin
              song_d   = song_inc;
              resume_d = 1'b1;
            end
            default: resume_d = 1'b1;
          endcase
        end else if (play_pause) begin
          state_d = S_PAUSE;
        end
      end
      default: state_d = resume_q ? S_PLAY : S_PAUSE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      song_q   <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      resume_q <= resume_d;
    end
  end

  assign play       = (state_q == S_PLAY);
  assign reset_play = (state_q == S_INIT) || (state_q == S_SWITCH);
  assign song       = song_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      s1_q    <= NewFrame;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      ready_q <= s2_q & ~s3_q;
    end
  end

  assign ready = ready_q;

  // the song-switch clear overrides a coincident ready pulse
  assign clr = (BEAT_SYNC != 0) && reset_play;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ready_q) begin
      cnt_d = (cnt_q == DM1) ? '0 : cnt_q + BEAT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat = ready_q && (cnt_q == DM1) && !clr;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Directed bench for music_player_ctrl: FSM vector table plus
// synchroniser / beat and async-reset sequences.
module tb_music_player_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_pause, next, prev, song_done, NewFrame;
  logic [1:0] mode;
  logic       play, reset_play, ready, beat;
  logic [1:0] song;

  int tests = 0;
  int fails = 0;
  int bcnt  = 0;

  typedef struct {
    logic       pp, nx, pv, dn;
    logic [1:0] md;
    logic       ep, er;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  music_player_ctrl #(
    .NUM_SONGS(3), .SONG_BITS(2), .BEAT_DIV(1000),
    .BEAT_BITS(10), .sim(1), .BEAT_SYNC(1)
  ) dut (
    .clk(clk), .reset(reset), .play_pause(play_pause),
    .next(next), .prev(prev), .mode(mode),
    .song_done(song_done), .NewFrame(NewFrame),
    .play(play), .reset_play(reset_play), .song(song),
    .ready(ready), .beat(beat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int pp, int nx, int pv, int md, int dn,
                              int ep, int er, int es);
    vec_t v;
    v.pp = 1'(pp); v.nx = 1'(nx); v.pv = 1'(pv);
    v.md = 2'(md); v.dn = 1'(dn);
    v.ep = 1'(ep); v.er = 1'(er); v.es = 2'(es);
    return v;
  endfunction

  task automatic frame(input bit sw);
    logic [4:0] rp, bp;
    logic       eb;
    eb = !sw && (bcnt == 63);
    NewFrame = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (sw && c == 2) next = 1'b1;
      step();
      next = 1'b0;
      if (c == 2) NewFrame = 1'b0;
      rp[c] = ready;
      bp[c] = beat;
    end
    chk("ready_pulse", 32'(rp), 32'h4);
    chk("beat_pulse", 32'(bp), eb ? 32'h4 : 32'h0);
    bcnt = sw ? 0 : (bcnt + 1) % 64;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    {play_pause, next, prev, song_done, NewFrame} = '0;
    mode = 2'b00;

    vecs.push_back(mk(0,1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,0,1,0,0, 0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 1,0,2));
    vecs.push_back(mk(0,1,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1));
    vecs.push_back(mk(0,1,0,1,0, 0,1,2));
    vecs.push_back(mk(0,0,0,1,0, 1,0,2));
    vecs.push_back(mk(0,0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,0,0));
    vecs.push_back(mk(1,0,0,3,0, 1,0,0));
    vecs.push_back(mk(0,1,0,3,0, 0,1,1));
    vecs.push_back(mk(0,0,0,3,0, 1,0,1));
    vecs.push_back(mk(0,0,0,3,1, 0,1,1));
    vecs.push_back(mk(0,0,0,3,0, 1,0,1));
    vecs.push_back(mk(0,1,0,3,0, 0,1,2));
    vecs.push_back(mk(0,0,0,3,0, 1,0,2));
    vecs.push_back(mk(0,1,0,3,0, 0,1,0));
    vecs.push_back(mk(0,0,0,3,0, 1,0,0));
    vecs.push_back(mk(0,1,0,3,1, 0,1,1));
    vecs.push_back(mk(0,0,0,3,0, 1,0,1));
    vecs.push_back(mk(1,0,0,3,0, 0,0,1));
    vecs.push_back(mk(0,1,0,3,0, 0,1,2));
    vecs.push_back(mk(0,1,0,3,0, 0,0,2));
    vecs.push_back(mk(1,0,0,0,0, 1,0,2));
    vecs.push_back(mk(0,0,0,0,1, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,2,0, 1,0,0));
    vecs.push_back(mk(0,0,1,2,0, 0,1,2));
    vecs.push_back(mk(0,0,0,2,0, 1,0,2));
    vecs.push_back(mk(0,0,0,2,1, 0,1,0));
    vecs.push_back(mk(0,0,0,2,0, 1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,1,1));
    vecs.push_back(mk(0,0,0,1,0, 1,0,1));
    vecs.push_back(mk(1,0,0,1,0, 0,0,1));
    vecs.push_back(mk(0,0,1,1,0, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0));

    #2;
    chk("rst_play", 32'(play), 32'd0);
    chk("rst_reset_play", 32'(reset_play), 32'd1);
    chk("rst_song", 32'(song), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("init_reset_play", 32'(reset_play), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      play_pause = vecs[i].pp;
      next       = vecs[i].nx;
      prev       = vecs[i].pv;
      mode       = vecs[i].md;
      song_done  = vecs[i].dn;
      step();
      {play_pause, next, prev, song_done} = '0;
      chk($sformatf("v%0d_play", i), 32'(play), 32'(vecs[i].ep));
      chk($sformatf("v%0d_rp", i), 32'(reset_play), 32'(vecs[i].er));
      chk($sformatf("v%0d_song", i), 32'(song), 32'(vecs[i].es));
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'd0);
    end

    mode = 2'b11;
    play_pause = 1'b1;
    step();
    play_pause = 1'b0;
    chk("beat_start_play", 32'(play), 32'd1);

    frames(64);
    frames(30);
    next = 1'b1;
    step();
    next = 1'b0;
    chk("sw_reset_play", 32'(reset_play), 32'd1);
    bcnt = 0;
    step();
    chk("sw_resume", 32'(play), 32'd1);
    frames(64);
    frames(63);
    frame(1'b1);
    frames(64);

    chk("pre_rst_play", 32'(play), 32'd1);
    chk("pre_rst_song", 32'(song), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    chk("async_play", 32'(play), 32'd0);
    chk("async_rp", 32'(reset_play), 32'd1);
    chk("async_song", 32'(song), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
